// File: rtl/alu_share_if.sv
// Request/response channels between two requesters and the shared-ALU sequencer.
interface alu_share_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OPW-1:0]   req_op0;
  logic [OPW-1:0]   req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_z;
  logic             rsp_zero;
  logic             rsp_err;

  // Requester side
  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_zero, rsp_err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters,
// one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_if.slave       bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_z,
  output logic             busy
);

  localparam logic [OPW-1:0] OP_AND = OPW'(0);
  localparam logic [OPW-1:0] OP_OR  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(6);
  localparam logic [OPW-1:0] OP_SLT = OPW'(7);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             grant_q, grant_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt_c;
  logic [OPW-1:0]   op_sel_c;
  logic [WIDTH-1:0] a_sel_c;
  logic [WIDTH-1:0] b_sel_c;
  logic             legal_c;
  logic [WIDTH-1:0] z_exec_c;
  logic [1:0]       req_ready_c;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Arbitration: rr pointer breaks ties, a lone requester wins outright
  always_comb begin
    gnt_c    = (&bus.req_valid) ? rr_q : bus.req_valid[1];
    op_sel_c = gnt_c ? bus.req_op1 : bus.req_op0;
    a_sel_c  = gnt_c ? bus.req_a1  : bus.req_a0;
    b_sel_c  = gnt_c ? bus.req_b1  : bus.req_b0;
    legal_c  = op_legal(op_sel_c);
    z_exec_c = illegal_q ? '0 : alu_z;
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    illegal_d   = illegal_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    req_ready_c = 2'b00;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          // ready is only offered to the granted port, so valid implies handshake
          req_ready_c[gnt_c] = 1'b1;
          grant_d   = gnt_c;
          illegal_d = ~legal_c;
          alu_a_d   = a_sel_c;
          alu_b_d   = b_sel_c;
          alu_op_d  = legal_c ? op_sel_c : OP_AND;
          rr_d      = ~gnt_c;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_z_d     = z_exec_c;
        rsp_zero_d  = (z_exec_c == '0);
        rsp_err_d   = illegal_q;
        rsp_valid_d = 2'b01 << grant_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      grant_q     <= 1'b0;
      illegal_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_z_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      illegal_q   <= illegal_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: queue-fed request driver, scoreboard monitor on the response side.
module tb_alu_share_ctrl;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ez;
    logic       eerr;
  } op_t;

  typedef struct {
    int         port;
    logic [3:0] z;
    logic       err;
    int         hs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_a, alu_b, alu_z;
  logic [2:0] alu_op;
  logic       busy;

  alu_share_if #(.WIDTH(4), .OPW(3)) bus ();

  alu_share_ctrl #(.WIDTH(4), .OPW(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_z  (alu_z),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_a & alu_b;
      3'b001:  alu_z = alu_a | alu_b;
      3'b010:  alu_z = alu_a + alu_b;
      3'b110:  alu_z = alu_a - alu_b;
      3'b111:  alu_z = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      default: alu_z = 4'b0000;
    endcase
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  int   gnt_log[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request driver: presents queue heads, records grants into the scoreboard
  initial begin
    bus.req_valid = 2'b00;
    bus.req_op0 = '0; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_op1 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.req_valid = 2'b00;
      end else begin
        if (q0.size() > 0) begin
          bus.req_valid[0] = 1'b1;
          bus.req_op0 = q0[0].op; bus.req_a0 = q0[0].a; bus.req_b0 = q0[0].b;
        end else bus.req_valid[0] = 1'b0;
        if (q1.size() > 0) begin
          bus.req_valid[1] = 1'b1;
          bus.req_op1 = q1[0].op; bus.req_a1 = q1[0].a; bus.req_b1 = q1[0].b;
        end else bus.req_valid[1] = 1'b0;
        #1;
        if (bus.req_valid[0] && bus.req_ready[0]) begin
          sb.push_back('{port: 0, z: q0[0].ez, err: q0[0].eerr, hs: cyc});
          gnt_log.push_back(0);
          void'(q0.pop_front());
        end
        if (bus.req_valid[1] && bus.req_ready[1]) begin
          sb.push_back('{port: 1, z: q1[0].ez, err: q1[0].eerr, hs: cyc});
          gnt_log.push_back(1);
          void'(q1.pop_front());
        end
      end
    end
  end

  // Response monitor: latency, hold stability, and content on each handshake
  initial begin
    logic       hold;
    logic [1:0] pv;
    logic [3:0] pz;
    logic       pzero, perr;
    exp_t       e;
    hold = 1'b0;
    pv = '0; pz = '0; pzero = 1'b0; perr = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
      end else if (bus.rsp_valid != 2'b00) begin
        if (hold) begin
          chk("hold_valid", 32'(bus.rsp_valid), 32'(pv));
          chk("hold_z", 32'({bus.rsp_z, bus.rsp_zero, bus.rsp_err}), 32'({pz, pzero, perr}));
        end
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_rsp: rsp_valid=%b with no outstanding request (t=%0t)",
                   bus.rsp_valid, $time);
          hold = 1'b0;
        end else begin
          if (!hold) chk("latency", 32'(cyc), 32'(sb[0].hs + 2));
          if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
            e = sb.pop_front();
            chk("rsp_owner", 32'(bus.rsp_valid), 32'(2'b01 << e.port));
            chk("rsp_z", 32'(bus.rsp_z), 32'(e.z));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.z == 4'b0000));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            hold = 1'b0;
          end else begin
            hold = 1'b1;
            pv = bus.rsp_valid; pz = bus.rsp_z; pzero = bus.rsp_zero; perr = bus.rsp_err;
          end
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (((q0.size() + q1.size() + sb.size()) != 0 || busy) && n < 80) begin
      tick();
      n++;
    end
    if (n >= 80) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    if (!busy) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: busy=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req_ready"}, 32'(bus.req_ready), 32'(0));
    chk({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    chk({name, "_rsp"}, 32'({bus.rsp_z, bus.rsp_zero, bus.rsp_err}), 32'(0));
    chk({name, "_alu"}, 32'({alu_a, alu_b, alu_op}), 32'(0));
    chk({name, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int n;
    bus.rsp_ready = 2'b11;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single add on port 0
    @(posedge clk);
    q0.push_back('{op: 3'b010, a: 4'b0011, b: 4'b0100, ez: 4'b0111, eerr: 1'b0});
    drain("single");

    // Subtract to zero, then signed slt, on port 1
    @(posedge clk);
    q1.push_back('{op: 3'b110, a: 4'b0101, b: 4'b0101, ez: 4'b0000, eerr: 1'b0});
    q1.push_back('{op: 3'b111, a: 4'b1110, b: 4'b0001, ez: 4'b0001, eerr: 1'b0});
    drain("sub_slt");

    // Both ports continuously requesting: strict alternation starting at port 0
    gnt_log.delete();
    @(posedge clk);
    q0.push_back('{op: 3'b010, a: 4'b0111, b: 4'b0001, ez: 4'b1000, eerr: 1'b0});
    q0.push_back('{op: 3'b000, a: 4'b1100, b: 4'b1010, ez: 4'b1000, eerr: 1'b0});
    q0.push_back('{op: 3'b001, a: 4'b0001, b: 4'b0100, ez: 4'b0101, eerr: 1'b0});
    q0.push_back('{op: 3'b110, a: 4'b0010, b: 4'b0011, ez: 4'b1111, eerr: 1'b0});
    q1.push_back('{op: 3'b010, a: 4'b1111, b: 4'b0001, ez: 4'b0000, eerr: 1'b0});
    q1.push_back('{op: 3'b111, a: 4'b0001, b: 4'b1110, ez: 4'b0000, eerr: 1'b0});
    q1.push_back('{op: 3'b000, a: 4'b1111, b: 4'b0101, ez: 4'b0101, eerr: 1'b0});
    q1.push_back('{op: 3'b001, a: 4'b0000, b: 4'b0000, ez: 4'b0000, eerr: 1'b0});
    drain("fair");
    chk("fair_count", 32'(gnt_log.size()), 32'(8));
    for (int i = 0; i < gnt_log.size() && i < 8; i++)
      chk($sformatf("fair_grant%0d", i), 32'(gnt_log[i]), 32'(i % 2));

    // Backpressure on port 0 while port 1 waits
    @(posedge clk);
    bus.rsp_ready = 2'b10;
    q0.push_back('{op: 3'b000, a: 4'b1111, b: 4'b0011, ez: 4'b0011, eerr: 1'b0});
    n = 0;
    while (bus.rsp_valid[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_rsp_seen", 32'(bus.rsp_valid), 32'(2'b01));
    q1.push_back('{op: 3'b001, a: 4'b1000, b: 4'b0001, ez: 4'b1001, eerr: 1'b0});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'(2'b01));
    end
    @(negedge clk);
    bus.rsp_ready = 2'b11;
    #3;
    tick();
    chk("bp_port1_granted", 32'(bus.req_ready), 32'(2'b10));
    drain("bp");

    // Illegal opcode: granted, alu_op forced to and, error response
    @(posedge clk);
    q0.push_back('{op: 3'b100, a: 4'b1010, b: 4'b0101, ez: 4'b0000, eerr: 1'b1});
    wait_busy("illegal");
    chk("illegal_alu_op", 32'(alu_op), 32'(0));
    drain("illegal");

    // Reset during EXEC discards the operation and restarts rr at port 0
    @(posedge clk);
    q0.push_back('{op: 3'b010, a: 4'b0001, b: 4'b0001, ez: 4'b0010, eerr: 1'b0});
    wait_busy("rst");
    chk("rst_exec_alu_op", 32'(alu_op), 32'(3'b010));
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sb.delete();
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'(0));
    gnt_log.delete();
    @(posedge clk);
    q0.push_back('{op: 3'b010, a: 4'b0010, b: 4'b0010, ez: 4'b0100, eerr: 1'b0});
    q1.push_back('{op: 3'b110, a: 4'b0000, b: 4'b0001, ez: 4'b1111, eerr: 1'b0});
    drain("post_rst");
    chk("post_rst_count", 32'(gnt_log.size()), 32'(2));
    if (gnt_log.size() > 0) chk("post_rst_first_grant", 32'(gnt_log[0]), 32'(0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences and shares one combinational 4-bit ALU (and/or/add/sub/slt datapath) between two requesters (port 0, port 1).
- Each requester presents an operation through a valid/ready request channel and receives its result through a valid/ready response channel.
- Arbitration is round-robin.
- Only one operation is in flight at a time; the block owns the ALU's a/b/op inputs.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU datapath width.
- OPW, 3, ALU opcode width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  bit i: requester i presents an operation
- req_ready  output  2  bit i: request i accepted this cycle (handshake = valid & ready)
- req_op0, req_op1  input  OPW each  opcode per requester
- req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands per requester
- rsp_valid  output  2  bit i: result for requester i available
- rsp_ready  input  2  bit i: requester i consumes result
- rsp_z  output  WIDTH  registered result (shared; qualified by rsp_valid)
- rsp_zero  output  1  rsp_z == 0
- rsp_err  output  1  illegal opcode flag for the current response
- alu_a, alu_b  output  WIDTH  ALU operand drive
- alu_op  output  OPW  ALU opcode drive
- alu_z  input  WIDTH  ALU combinational result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0; rsp_valid=0; rsp_z=0; rsp_zero=0; rsp_err=0; alu_a=0; alu_b=0; alu_op=0; rr pointer=0 (port 0 favoured first); busy=0.
- Legal opcodes: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- Illegal opcodes: 011, 100, 101. An illegal opcode is still granted and responds with rsp_z=0, rsp_err=1. alu_op is driven 000 for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant one: if both are set, grant the port indicated by the rr pointer; otherwise grant the single one.
  - req_ready[g]=1 combinationally in IDLE for the granted port only.
  - On the handshake, latch op/a/b into operand registers and the grant index, then go to EXEC.
  - The rr pointer is then set to the non-granted port.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op are driven from the operand registers; they are registered outputs, valid from the first EXEC cycle.
  - At the end of EXEC, capture rsp_z = alu_z (or 0 if illegal), rsp_zero, rsp_err; go to RESP.
- RESP:
  - rsp_valid[grant]=1, other bit 0.
  - Hold rsp_z/rsp_zero/rsp_err stable until rsp_ready[grant]=1, then clear rsp_valid and go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency: request handshake at cycle N -> rsp_valid high at cycle N+2. Minimum issue interval is 3 cycles per operation.
- alu_* hold their last values outside EXEC; no glitching between operations.
- req_ready=0 in EXEC and RESP; new requests wait (valid must stay asserted, operands stable, per handshake rule).
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…
- Width rules: add/sub wrap modulo 2^WIDTH; overflow is not reported. slt result is 0…01 or 0.
- Reset asserted mid-operation: immediate return to reset values; the in-flight operation is discarded with no response.
- A requester dropping req_valid before its handshake is legal; no grant is recorded and the rr pointer is unchanged.

Test Plan:
- Reset then single request: port0 op=010 a=0011 b=0100 -> rsp_valid=01 two cycles after handshake, rsp_z=0111, rsp_zero=0, rsp_err=0.
- Subtract/slt/zero:
  - port1 op=110 a=0101 b=0101 -> rsp_z=0000, rsp_zero=1.
  - port1 op=111 a=1110(-2) b=0001 -> rsp_z=0001.
- Both ports valid continuously, 4 ops each -> grant order 0,1,0,1,…; each response goes only to its owner; add 0111+0001 wraps to 1000.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles -> rsp_valid/rsp_z stable, req_ready=00 throughout, port1 waits; release -> port1 granted next IDLE cycle.
- Illegal op 100 on port0 -> rsp_err=1, rsp_z=0000, alu_op=000 during EXEC.
- Assert rst_n=0 during EXEC -> all outputs zero immediately, no rsp_valid after release; next request is served normally with rr pointer at port 0.
